// File: rtl/back_propagation_nn.sv
// back_propagation_nn: online-training 4-2-2 net, one sample per epoch.
// Forward pass, 1-bit decisions, then in-place backprop weight update.
module back_propagation_nn #(
  parameter int EPOCH_CYCLES = 24,
  parameter int LR_SHIFT     = 10,
  parameter int W_W          = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic signed [8:0] x0,
  input  logic signed [8:0] x1,
  input  logic signed [8:0] x2,
  input  logic signed [8:0] x3,
  input  logic signed [8:0] desired_y0,
  input  logic signed [8:0] desired_y1,
  output logic              y0,
  output logic              y1
);

  localparam int CW    = $clog2(EPOCH_CYCLES);
  localparam int W_MAX = 2**(W_W-1) - 1;
  localparam int W_MIN = -(2**(W_W-1));

  localparam logic signed [W_W-1:0] W_P = W_W'(64);
  localparam logic signed [W_W-1:0] W_N = W_W'(-64);
  localparam logic signed [W_W-1:0] W_1 = W_W'(256);
  localparam logic signed [W_W-1:0] W_M = W_W'(-256);

  typedef enum logic [2:0] {
    S_CAPTURE, S_HIDDEN, S_OUTPUT, S_ERROR,
    S_BACKPROP, S_UPDATE, S_WAIT
  } state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;

  logic signed [W_W-1:0] r_w1 [2][4];
  logic signed [W_W-1:0] r_w2 [2][2];
  logic signed [8:0]     r_x  [4];
  logic signed [8:0]     r_dy [2];
  logic signed [7:0]     r_h  [2];
  logic [1:0]            r_dv;
  logic signed [31:0]    r_o  [2];
  logic signed [9:0]     r_e  [2];
  logic signed [31:0]    r_g  [2];
  logic [1:0]            r_y;

  logic signed [31:0]    w_s  [2];
  logic signed [31:0]    w_sh [2];
  logic signed [7:0]     w_h  [2];
  logic [1:0]            w_dv;
  logic signed [31:0]    w_o  [2];
  logic signed [9:0]     w_e  [2];
  logic signed [31:0]    w_g  [2];
  logic signed [W_W-1:0] w_w1_nx [2][4];
  logic signed [W_W-1:0] w_w2_nx [2][2];

  function automatic logic signed [7:0] clamp8(
    input logic signed [31:0] v
  );
    if (v > 127)       return 8'sd127;
    else if (v < -128) return -8'sd128;
    else               return v[7:0];
  endfunction

  function automatic logic signed [W_W-1:0] sat_add(
    input logic signed [W_W-1:0] w,
    input logic signed [31:0]    d
  );
    logic signed [31:0] t;
    t = 32'(w) + d;
    if (t > W_MAX)      return W_W'(W_MAX);
    else if (t < W_MIN) return W_W'(W_MIN);
    else                return W_W'(t);
  endfunction

  assign y0 = r_y[0];
  assign y1 = r_y[1];

  // state and epoch counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_CAPTURE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // fixed stage sequence, padding in WAIT until the counter wraps
  always_comb begin
    w_cnt_nx   = (r_cnt == CW'(EPOCH_CYCLES-1)) ? '0 : r_cnt + CW'(1);
    w_state_nx = r_state;
    unique case (r_state)
      S_CAPTURE:  w_state_nx = S_HIDDEN;
      S_HIDDEN:   w_state_nx = S_OUTPUT;
      S_OUTPUT:   w_state_nx = S_ERROR;
      S_ERROR:    w_state_nx = S_BACKPROP;
      S_BACKPROP: w_state_nx = S_UPDATE;
      S_UPDATE:   w_state_nx = S_WAIT;
      S_WAIT:
        if (r_cnt == CW'(EPOCH_CYCLES-1)) w_state_nx = S_CAPTURE;
      default:    w_state_nx = S_CAPTURE;
    endcase
  end

  // forward, error, gradient and next-weight arithmetic
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_s[j]  = 32'(r_w1[j][0]) * 32'(r_x[0])
              + 32'(r_w1[j][1]) * 32'(r_x[1])
              + 32'(r_w1[j][2]) * 32'(r_x[2])
              + 32'(r_w1[j][3]) * 32'(r_x[3]);
      w_sh[j] = w_s[j] >>> 8;
      w_dv[j] = (w_sh[j] >= -128) && (w_sh[j] <= 127);
      w_h[j]  = clamp8(w_sh[j]);
    end
    for (int k = 0; k < 2; k++) begin
      w_o[k] = (32'(r_w2[k][0]) * 32'(r_h[0])
              + 32'(r_w2[k][1]) * 32'(r_h[1])) >>> 8;
      w_e[k] = ((r_dy[k] > 0) ? 10'sd64 : -10'sd64)
             - 10'(clamp8(r_o[k]));
    end
    for (int j = 0; j < 2; j++) begin
      w_g[j] = r_dv[j]
             ? ((32'(r_w2[0][j]) * 32'(r_e[0])
               + 32'(r_w2[1][j]) * 32'(r_e[1])) >>> 8)
             : 32'sd0;
    end
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 2; j++)
        w_w2_nx[k][j] = sat_add(r_w2[k][j],
          (32'(r_e[k]) * 32'(r_h[j])) >>> LR_SHIFT);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++)
        w_w1_nx[j][i] = sat_add(r_w1[j][i],
          (r_g[j] * 32'(r_x[i])) >>> LR_SHIFT);
  end

  // per-stage pipeline registers and in-place weight update
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_w1[0] <= '{W_P, W_P, W_P, W_P};
      r_w1[1] <= '{W_P, W_N, W_P, W_N};
      r_w2[0] <= '{W_1, W_1};
      r_w2[1] <= '{W_1, W_M};
      r_x     <= '{4{9'sd0}};
      r_dy    <= '{2{9'sd0}};
      r_h     <= '{2{8'sd0}};
      r_dv    <= '0;
      r_o     <= '{2{32'sd0}};
      r_e     <= '{2{10'sd0}};
      r_g     <= '{2{32'sd0}};
      r_y     <= '0;
    end else begin
      unique case (r_state)
        S_CAPTURE: begin
          r_x  <= '{x0, x1, x2, x3};
          r_dy <= '{desired_y0, desired_y1};
        end
        S_HIDDEN: begin
          r_h  <= w_h;
          r_dv <= w_dv;
        end
        S_OUTPUT:   r_o <= w_o;
        S_ERROR: begin
          r_y <= {r_o[1] > 0, r_o[0] > 0};
          r_e <= w_e;
        end
        S_BACKPROP: r_g <= w_g;
        S_UPDATE: begin
          r_w1 <= w_w1_nx;
          r_w2 <= w_w2_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_back_propagation_nn.sv
// tb_back_propagation_nn: random online training against an
// integer reference model of the 4-2-2 net, plus literal anchors.
module tb_back_propagation_nn;

  logic              CLK = 1'b0;
  logic              RST;
  logic signed [8:0] x0, x1, x2, x3, dy0, dy1;
  logic              y0, y1;

  back_propagation_nn dut (
    .CLK(CLK), .RST(RST),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .desired_y0(dy0), .desired_y1(dy1),
    .y0(y0), .y1(y1)
  );

  always #5 CLK = ~CLK;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   mw1 [2][4];
  int   mw2 [2][2];
  logic exp_y0 = 1'b0;
  logic exp_y1 = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_init();
    mw1[0] = '{64, 64, 64, 64};
    mw1[1] = '{64, -64, 64, -64};
    mw2[0] = '{256, 256};
    mw2[1] = '{256, -256};
  endtask

  // one full epoch of the net: decisions out, weights updated
  task automatic model_epoch(input int xv[4], input int d[2],
                             output logic yo0, output logic yo1);
    int s, h[2], dv[2], o[2], e[2], g[2];
    for (int j = 0; j < 2; j++) begin
      s = 0;
      for (int i = 0; i < 4; i++) s += mw1[j][i] * xv[i];
      s = s >>> 8;
      dv[j] = (s >= -128 && s <= 127) ? 1 : 0;
      h[j]  = clamp(s, -128, 127);
    end
    for (int k = 0; k < 2; k++) begin
      o[k] = (mw2[k][0] * h[0] + mw2[k][1] * h[1]) >>> 8;
      e[k] = ((d[k] > 0) ? 64 : -64) - clamp(o[k], -128, 127);
    end
    yo0 = o[0] > 0;
    yo1 = o[1] > 0;
    for (int j = 0; j < 2; j++)
      g[j] = dv[j] ? ((mw2[0][j] * e[0] + mw2[1][j] * e[1]) >>> 8) : 0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 2; j++)
        mw2[k][j] = clamp(mw2[k][j] + ((e[k] * h[j]) >>> 10),
                          -32768, 32767);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++)
        mw1[j][i] = clamp(mw1[j][i] + ((g[j] * xv[i]) >>> 10),
                          -32768, 32767);
  endtask

  task automatic check_weights(input string tag);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s w1[%0d][%0d]", tag, j, i),
            int'(dut.r_w1[j][i]), mw1[j][i]);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 2; j++)
        chk($sformatf("%s w2[%0d][%0d]", tag, k, j),
            int'(dut.r_w2[k][j]), mw2[k][j]);
  endtask

  task automatic scramble();
    x0  = 9'($urandom);
    x1  = 9'($urandom);
    x2  = 9'($urandom);
    x3  = 9'($urandom);
    dy0 = 9'($urandom);
    dy1 = 9'($urandom);
  endtask

  // drive one sample, called just before the CAPTURE edge
  task automatic epoch(input int xv[4], input int d[2],
                       input bit scr, output logic ey0,
                       output logic ey1);
    x0  = 9'(xv[0]);
    x1  = 9'(xv[1]);
    x2  = 9'(xv[2]);
    x3  = 9'(xv[3]);
    dy0 = 9'(d[0]);
    dy1 = 9'(d[1]);
    model_epoch(xv, d, ey0, ey1);
    repeat (4) begin
      @(posedge CLK); #1;
      if (scr) scramble();
    end
    exp_y0 = ey0;
    exp_y1 = ey1;
    repeat (2) @(posedge CLK);
    #1;
    check_weights("upd");
    repeat (18) begin
      @(posedge CLK); #1;
      if (scr) scramble();
    end
  endtask

  // decisions compared every cycle, away from the active edge
  always @(negedge CLK) begin
    n_chk++;
    if (y0 !== exp_y0 || y1 !== exp_y1) begin
      n_fail++;
      $display("FAIL y t=%0t: got %b%b expected %b%b",
               $time, y0, y1, exp_y0, exp_y1);
    end
  end

  initial begin
    int   xv[4];
    int   d[2];
    logic ey0, ey1;
    int   agree;
    RST = 1'b0;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0; dy0 = '0; dy1 = '0;
    model_init();
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_weights("rst");
    chk("cnt_rst", int'(dut.r_cnt), 0);
    chk("w1_11_lit", int'(dut.r_w1[1][1]), -64);
    RST = 1'b0;

    xv = '{100, 100, 100, 100};
    d  = '{1, 1};
    epoch(xv, d, 1'b1, ey0, ey1);
    chk("y0_fwd", int'(y0), 1);
    chk("y1_fwd", int'(y1), 1);
    chk("w2_00_lit", int'(dut.r_w2[0][0]), 252);
    chk("w2_10_lit", int'(dut.r_w2[1][0]), 252);
    chk("w2_01_lit", int'(dut.r_w2[0][1]), 256);
    chk("w2_11_lit", int'(dut.r_w2[1][1]), -256);
    chk("w1_00_lit", int'(dut.r_w1[0][0]), 56);
    chk("w1_11_upd", int'(dut.r_w1[1][1]), -64);

    xv = '{0, 0, 0, 0};
    d  = '{-5, 7};
    epoch(xv, d, 1'b1, ey0, ey1);
    chk("y0_zero", int'(y0), 0);
    chk("y1_zero", int'(y1), 0);
    chk("w2_00_zero", int'(dut.r_w2[0][0]), 252);
    chk("w1_00_zero", int'(dut.r_w1[0][0]), 56);

    x0 = 9'sd50; x1 = -9'sd80; x2 = 9'sd120; x3 = 9'sd7;
    dy0 = 9'sd3; dy1 = -9'sd3;
    repeat (4) @(posedge CLK);
    #1;
    RST    = 1'b1;
    exp_y0 = 1'b0;
    exp_y1 = 1'b0;
    model_init();
    #2;
    check_weights("midrst");
    chk("cnt_midrst", int'(dut.r_cnt), 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    xv = '{100, 100, 100, 100};
    d  = '{1, 1};
    epoch(xv, d, 1'b0, ey0, ey1);
    chk("w2_00_after_rst", int'(dut.r_w2[0][0]), 252);

    agree = 0;
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 4; i++) xv[i] = $urandom_range(200) - 100;
      d[0] = (xv[0] + xv[1] - xv[2] > 0) ? 40 : -40;
      d[1] = (xv[3] - xv[0] > 0) ? 40 : -40;
      epoch(xv, d, 1'b1, ey0, ey1);
      if (n >= 180)
        agree += int'(ey0 == (d[0] > 0)) + int'(ey1 == (d[1] > 0));
    end
    $display("info: final-20 agreement with targets %0d/40", agree);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
